lut_layer_sequencer: RTL and testbench
======================================

// Module: lut_layer_sequencer
// PURPOSE
//  Time-multiplexes one shared, runtime-loadable truth-table RAM across all NEURONS neurons of a LogicNets layer.
//  Evaluates one neuron per cycle: gathers FANIN input elements through a connectivity table and forms an 8-bit LUT address.
//  Collects the OUT_BW-bit results into an output vector.
//  Sits between quantised layer activations (upstream valid/ready) and the next layer; replaces NEURONS fixed ROMs when area matters.
// PARAMETERS
//  IN_ELEMS  16  input vector elements
//  BW        2   bits per input element
//  FANIN     4   inputs per neuron; LUT address width AW = FANIN*BW = 8
//  NEURONS   16  neurons evaluated per input vector
//  OUT_BW    2   bits per neuron output
// PORTS
//  clk        in   1                  single clock, rising edge
//  rst_n      in   1                  asynchronous, active-low reset
//  in_valid   in   1                  input vector valid
//  in_ready   out  1                  sequencer can accept a vector
//  in_data    in   IN_ELEMS*BW        element e = in_data[e*BW +: BW]
//  out_valid  out  1                  result vector valid
//  out_ready  in   1                  downstream accepts result
//  out_data   out  NEURONS*OUT_BW     neuron n = out_data[n*OUT_BW +: OUT_BW]
//  cfg_valid  in   1                  config write request
//  cfg_ready  out  1                  config write accepted this cycle
//  cfg_sel    in   1                  0 = truth table, 1 = connectivity
//  cfg_addr   in   $clog2(NEURONS)+AW table: {neuron,lut_addr}; conn: neuron in LSBs
//  cfg_wdata  in   16                 table: [OUT_BW-1:0]; conn: FANIN indices, $clog2(IN_ELEMS) bits each, index k in LSB-first slot k
//  cfg_rdata  out  16                 readback data (CFG_READBACK_EN only)
// BEHAVIOUR
//  Reset values: in_ready=1, cfg_ready=1, out_valid=0, out_data=0, cfg_rdata=0, FSM=IDLE.
//    RAM contents are not reset.
//  FSM IDLE -> EVAL on in_valid&&in_ready; in_data latched, neuron counter n=0.
//  EVAL: cycle k issues RAM read for neuron k; address = {k, elem[idx[FANIN-1]],...,elem[idx[0]]}.
//    elem[idx[0]] occupies the address LSBs.
//    Synchronous read; result of neuron k is written into out_data slot k one cycle later.
//  EVAL -> DONE when the last result is captured; out_valid rises NEURONS+1 cycles after the accept edge.
//  DONE: out_valid and out_data held stable until out_ready.
//    out_valid&&out_ready -> IDLE, with in_ready=1 the next cycle; no bypass.
//  in_ready=1 only in IDLE; in_valid elsewhere is ignored and not lost upstream.
//  cfg_ready=1 only in IDLE; writes take effect on the accept edge.
//    Simultaneous cfg_valid and in_valid in IDLE: the config write wins, in_ready=0 that cycle.
//  Connectivity index >= IN_ELEMS selects element 0.
//  n wraps never: it stops at NEURONS-1. Counters are sized $clog2(NEURONS), with NEURONS a power of two.
//  rst_n low mid-EVAL/DONE aborts the vector; outputs return to reset values asynchronously.
// CONFIGURATION
//  CFG_READBACK_EN defined:
//    a cfg_valid with cfg_wdata[15]=1 (table) or cfg_addr MSB=1 (conn) is a read, not a write.
//    cfg_rdata is valid one cycle after acceptance; tables are unchanged.
//  CFG_READBACK_EN undefined: all cfg requests are writes, and cfg_rdata is tied to 0.
// STRUCTURE
//  Package lut_seq_pkg: state enum {IDLE,EVAL,DONE}, CFG_SEL_TABLE/CFG_SEL_CONN constants, and AW/IDX_W/CFG_W localparam helpers.
//  Sub-module lut_seq_tbl_ram: NEURONS*2^AW x OUT_BW RAM, 1 write port, 1 synchronous read port, distributed style.
//    The connectivity table is a flop array inside the top.
// TESTING
//  Program table[n][a] = a[1:0]^n[1:0] and conn[n][k] = (n+k)%16; send in_data=0.
//    -> out_data slot n = n[1:0]; out_valid exactly 17 cycles after accept.
//  Same config; in_data = all elements 2'b11.
//    -> slot n = 2'b11^n[1:0].
//  Hold out_ready=0 for 10 cycles in DONE.
//    -> out_valid, out_data stable; in_ready=0, cfg_ready=0 throughout.
//  cfg_valid and in_valid asserted together in IDLE.
//    -> write accepted, in_ready=0; vector accepted next cycle with the new table.
//  rst_n pulsed low at EVAL cycle 5.
//    -> out_valid=0 immediately, in_ready=1 after release, and the next vector evaluates correctly.
//  CFG_READBACK_EN: write table {3,8'h5A}=2'b10, then read it back.
//    -> cfg_rdata=16'h0002 one cycle later; without the macro, cfg_rdata stays 0.

Source files
------------

// File: rtl/lut_seq_pkg.sv
// Shared types and sizing helpers for the LUT layer sequencer.
package lut_seq_pkg;

  localparam int DEF_IN_ELEMS = 16;
  localparam int DEF_BW       = 2;
  localparam int DEF_FANIN    = 4;
  localparam int DEF_NEURONS  = 16;
  localparam int DEF_OUT_BW   = 2;

  // LUT address width, connectivity index width, config data width
  localparam int AW    = DEF_FANIN * DEF_BW;
  localparam int IDX_W = $clog2(DEF_IN_ELEMS);
  localparam int CFG_W = 16;

  localparam logic CFG_SEL_TABLE = 1'b0;
  localparam logic CFG_SEL_CONN  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lut_seq_tbl_ram.sv
// Shared truth-table RAM: one write port, one synchronous read port.
// Contents are not reset; read-during-write returns the old word.
module lut_seq_tbl_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: evaluates one neuron per cycle through a
// shared runtime-loadable truth-table RAM and a flop-based connectivity table.
// Optional feature macro: CFG_READBACK_EN (config read requests + cfg_rdata).
module lut_layer_sequencer
  import lut_seq_pkg::*;
#(
  parameter int IN_ELEMS = DEF_IN_ELEMS,
  parameter int BW       = DEF_BW,
  parameter int FANIN    = DEF_FANIN,
  parameter int NEURONS  = DEF_NEURONS,
  parameter int OUT_BW   = DEF_OUT_BW
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [IN_ELEMS*BW-1:0]                in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NEURONS*OUT_BW-1:0]             out_data,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic                                  cfg_sel,
  input  logic [$clog2(NEURONS)+FANIN*BW-1:0]   cfg_addr,
  input  logic [CFG_W-1:0]                      cfg_wdata,
  output logic [CFG_W-1:0]                      cfg_rdata
);

  localparam int A_W    = FANIN * BW;
  localparam int I_W    = $clog2(IN_ELEMS);
  localparam int N_W    = $clog2(NEURONS);
  localparam int CA_W   = N_W + A_W;
  localparam int CONN_W = FANIN * I_W;

  state_e                      state_q, state_d;
  logic [N_W-1:0]              n_q, n_d;
  logic                        issued_q, issued_d;
  logic                        rd_vld_q, rd_vld_d;
  logic [N_W-1:0]              rd_idx_q, rd_idx_d;
  logic [IN_ELEMS*BW-1:0]      data_q, data_d;
  logic [NEURONS*OUT_BW-1:0]   out_data_q, out_data_d;
  logic [CONN_W-1:0]           conn_q [NEURONS];
  logic [CONN_W-1:0]           conn_d [NEURONS];
  logic [A_W-1:0]              lut_addr;
  logic [CA_W-1:0]             ram_raddr;
  logic [OUT_BW-1:0]           ram_rdata;
  logic                        ram_we;
  logic                        cfg_acc;
  logic                        cfg_rd_req;

  // Out-of-range connectivity indices fall back to element 0
  function automatic logic [BW-1:0] sel_elem(input logic [IN_ELEMS*BW-1:0] vec,
                                             input logic [I_W-1:0] idx);
    int unsigned i;
    i = 32'(idx);
    if (i < IN_ELEMS) return vec[i*BW +: BW];
    return vec[BW-1:0];
  endfunction

  // Config takes priority over a new vector while idle
  assign cfg_ready = (state_q == IDLE);
  assign in_ready  = (state_q == IDLE) && !cfg_valid;
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;

`ifdef CFG_READBACK_EN
  assign cfg_rd_req = (cfg_sel == CFG_SEL_TABLE) ? cfg_wdata[CFG_W-1] : cfg_addr[CA_W-1];
`else
  assign cfg_rd_req = 1'b0;
`endif

  assign ram_we    = cfg_acc && !cfg_rd_req && (cfg_sel == CFG_SEL_TABLE);
  // RAM read port serves evaluation; while idle it follows cfg_addr for readback
  assign ram_raddr = (state_q == EVAL) ? {n_q, lut_addr} : cfg_addr;

  lut_seq_tbl_ram #(
    .ADDR_W (CA_W),
    .DATA_W (OUT_BW)
  ) u_tbl_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata[OUT_BW-1:0]),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Gather the current neuron's fan-in elements; index 0 lands in the LSBs
  always_comb begin
    lut_addr = '0;
    for (int k = 0; k < FANIN; k++) begin
      lut_addr[k*BW +: BW] = sel_elem(data_q, conn_q[n_q][k*I_W +: I_W]);
    end
  end

  // Connectivity table writes and input vector latch
  always_comb begin
    conn_d = conn_q;
    data_d = data_q;
    if (cfg_acc && !cfg_rd_req && (cfg_sel == CFG_SEL_CONN)) begin
      conn_d[cfg_addr[N_W-1:0]] = cfg_wdata[CONN_W-1:0];
    end
    if (in_valid && in_ready) data_d = in_data;
  end

  // Table storage, no reset
  always_ff @(posedge clk) begin
    conn_q <= conn_d;
    data_q <= data_d;
  end

  // Sequencer next state: issue reads n=0..NEURONS-1, then wait for last capture
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    issued_d = issued_q;
    rd_vld_d = 1'b0;
    rd_idx_d = rd_idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d  = EVAL;
          n_d      = '0;
          issued_d = 1'b0;
        end
      end
      EVAL: begin
        if (!issued_q) begin
          rd_vld_d = 1'b1;
          rd_idx_d = n_q;
          if (n_q == N_W'(NEURONS-1)) issued_d = 1'b1;
          else                        n_d      = n_q + 1'b1;
        end
        if (rd_vld_q && (rd_idx_q == N_W'(NEURONS-1))) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result capture one cycle after each RAM read
  always_comb begin
    out_data_d = out_data_q;
    if (rd_vld_q) out_data_d[rd_idx_q*OUT_BW +: OUT_BW] = ram_rdata;
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      issued_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      issued_q   <= issued_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef CFG_READBACK_EN
  logic             rb_tbl_q, rb_tbl_d;
  logic [CFG_W-1:0] cfg_rdata_q, cfg_rdata_d;

  // Readback: conn words captured at accept; table words come from the RAM a cycle later
  always_comb begin
    rb_tbl_d    = cfg_acc && cfg_rd_req && (cfg_sel == CFG_SEL_TABLE);
    cfg_rdata_d = cfg_rdata_q;
    if (rb_tbl_q) cfg_rdata_d = CFG_W'(ram_rdata);
    if (cfg_acc && cfg_rd_req && (cfg_sel == CFG_SEL_CONN)) begin
      cfg_rdata_d = CFG_W'(conn_q[cfg_addr[N_W-1:0]]);
    end
  end

  // Readback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_tbl_q    <= 1'b0;
      cfg_rdata_q <= '0;
    end else begin
      rb_tbl_q    <= rb_tbl_d;
      cfg_rdata_q <= cfg_rdata_d;
    end
  end

  assign cfg_rdata = rb_tbl_q ? CFG_W'(ram_rdata) : cfg_rdata_q;
`else
  assign cfg_rdata = '0;
`endif

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer with a queue-based result scoreboard.
module tb_lut_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_sel;
  logic [11:0] cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] sb [$];
  logic [1:0]  tbl [16][256];
  logic [3:0]  cn  [16][4];

  always #5 clk = ~clk;

  lut_layer_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_addr(input int n, input logic [31:0] v);
    logic [7:0] a;
    int idx;
    a = '0;
    for (int k = 0; k < 4; k++) begin
      idx = int'(cn[n][k]);
      a[k*2 +: 2] = (idx < 16) ? v[idx*2 +: 2] : v[1:0];
    end
    return a;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[n*2 +: 2] = tbl[n][model_addr(n, v)];
    return r;
  endfunction

  task automatic cfg_wr(input logic sel, input logic [11:0] addr, input logic [15:0] wd);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_wdata = wd;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    in_data  = v;
    in_valid = 1'b1;
    #1;
    chk("in_ready_at_accept", {63'd0, in_ready}, 64'd1);
    sb.push_back(model(v));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat, input bit hold);
    int c;
    logic [31:0] exp_v;
    logic [31:0] held;
    c = 0;
    while (!out_valid && c < 100) begin
      tick();
      c++;
    end
    chk("out_valid_latency", 64'(c), 64'(exp_lat));
    chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      chk("out_data", {32'd0, out_data}, {32'd0, exp_v});
    end
    if (hold) begin
      held = out_data;
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_out_data", {32'd0, out_data}, {32'd0, held});
        chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        chk("hold_cfg_ready", {63'd0, cfg_ready}, 64'd0);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_done_out_valid", {63'd0, out_valid}, 64'd0);
    chk("post_done_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  a;
    logic [1:0]  nv;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cfg_valid = 1'b0;
    cfg_sel   = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_cfg_rdata", {48'd0, cfg_rdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Program truth tables and connectivity
    for (int n = 0; n < 16; n++) begin
      for (int ad = 0; ad < 256; ad++) begin
        tbl[n][ad] = 2'(ad) ^ 2'(n);
        cfg_wr(1'b0, {4'(n), 8'(ad)}, {14'd0, tbl[n][ad]});
      end
    end
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 4; k++) cn[n][k] = 4'((n + k) % 16);
      cfg_wr(1'b1, 12'(n), {cn[n][3], cn[n][2], cn[n][1], cn[n][0]});
    end

    // All-zero vector: slot n = n[1:0]
    send(32'h0000_0000);
    wait_result(17, 1'b0);

    // All-ones vector with backpressure in DONE
    send(32'hFFFF_FFFF);
    wait_result(17, 1'b1);

    // Simultaneous config and vector: config wins, vector follows with new table
    v  = 32'hE4E4_E4E4;
    a  = model_addr(1, v);
    nv = ~(a[1:0] ^ 2'd1);
    cfg_valid = 1'b1;
    cfg_sel   = 1'b0;
    cfg_addr  = {4'd1, a};
    cfg_wdata = {14'd0, nv};
    in_valid  = 1'b1;
    in_data   = v;
    #1;
    chk("collide_in_ready", {63'd0, in_ready}, 64'd0);
    chk("collide_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    tbl[1][a] = nv;
    tick();
    cfg_valid = 1'b0;
    send(v);
    wait_result(17, 1'b0);

    // Asynchronous reset in the middle of evaluation
    send(32'h1234_5678);
    repeat (5) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_out_data", {32'd0, out_data}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    v = $urandom;
    send(v);
    wait_result(17, 1'b0);

    // Config readback path
`ifdef CFG_READBACK_EN
    cfg_wr(1'b0, {4'd3, 8'h5A}, 16'h0002);
    tbl[3][8'h5A] = 2'b10;
    cfg_wr(1'b0, {4'd3, 8'h5A}, 16'h8000);
    chk("readback_table", {48'd0, cfg_rdata}, 64'h0002);
`else
    cfg_wr(1'b0, {4'd3, 8'h5A}, 16'h0002);
    tbl[3][8'h5A] = 2'b10;
    chk("rdata_tied_zero_a", {48'd0, cfg_rdata}, 64'd0);
    cfg_wr(1'b0, {4'd3, 8'h5A}, 16'h8000);
    tbl[3][8'h5A] = 2'b00;
    chk("rdata_tied_zero_b", {48'd0, cfg_rdata}, 64'd0);
`endif

    // Final random vector against the updated tables
    v = $urandom;
    send(v);
    wait_result(17, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
